// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data arbiter in front of mem_system.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  localparam int DEF_TIMEOUT       = 64;
  localparam int DEF_MAX_DM_STREAK = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, halt and mem_system signals around the arbiter.
// The arbiter is the slave of the requesters; the surrounding pipeline/memory side uses master.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();
  logic          if_rd;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_err;

  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          dm_err;

  logic          halt;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          mem_err;

  logic          busy;

  modport slave (
    input  if_rd, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, halt,
           mem_rdata, mem_done, mem_err,
    output if_rdata, if_done, if_err, dm_rdata, dm_done, dm_err,
           mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );

  modport master (
    output if_rd, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, halt,
           mem_rdata, mem_done, mem_err,
    input  if_rdata, if_done, if_err, dm_rdata, dm_done, dm_err,
           mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Loadable, clearable up-counter; o_tc flags the final allowed count and the counter holds there.
module mem_arb_timer #(
  parameter int TIMEOUT = 64,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_system between fetch (read-only) and data (read/write) ports,
// one transaction at a time, data-first with a bounded streak while fetch waits.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t    r_state;
  arb_state_t    w_nxt_state;
  arb_owner_t    r_owner;
  arb_op_t       r_op;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic [SW-1:0] r_streak;

  logic          w_fetch_ok;
  logic          w_dm_req;
  logic          w_fetch_turn;
  logic          w_grant;
  logic          w_gnt_dm;
  logic          w_mem_fin;
  logic          w_tc;
  logic          w_tc_hit;
  logic          w_complete;
  logic          w_resp_if;
  logic          w_resp_dm;

  assign w_fetch_ok   = bus.if_rd & ~bus.halt;
  assign w_dm_req     = bus.dm_rd | bus.dm_wr;
  assign w_fetch_turn = w_fetch_ok && (r_streak == SW'(MAX_DM_STREAK));
  assign w_mem_fin    = bus.mem_done | bus.mem_err;
  assign w_tc_hit     = (r_state == WAIT) && w_tc;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (r_state == ISSUE),
    .i_load     (1'b0),
    .i_load_val (CW'(0)),
    .i_en       (r_state == WAIT),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_grant     = 1'b0;
    w_gnt_dm    = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dm_req && !w_fetch_turn) begin
          w_grant     = 1'b1;
          w_gnt_dm    = 1'b1;
          w_nxt_state = ISSUE;
        end else if (w_fetch_ok) begin
          w_grant     = 1'b1;
          w_nxt_state = ISSUE;
        end
      end
      ISSUE: begin
        w_complete  = w_mem_fin;
        w_nxt_state = w_mem_fin ? RESP : WAIT;
      end
      WAIT: begin
        if (w_mem_fin || w_tc_hit) begin
          w_complete  = 1'b1;
          w_nxt_state = RESP;
        end
      end
      RESP: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  // Holding registers: request latched at grant, response captured at completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner  <= OWN_IF;
      r_op     <= OP_RD;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_streak <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_gnt_dm ? OWN_DM : OWN_IF;
        r_op    <= (w_gnt_dm && bus.dm_wr) ? OP_WR : OP_RD;
        r_addr  <= w_gnt_dm ? bus.dm_addr : bus.if_addr;
        r_wdata <= (w_gnt_dm && bus.dm_wr) ? bus.dm_wdata : '0;
        if (w_gnt_dm && bus.if_rd) begin
          if (r_streak != SW'(MAX_DM_STREAK)) begin
            r_streak <= r_streak + SW'(1);
          end
        end else begin
          r_streak <= '0;
        end
      end
      if (w_complete) begin
        r_rdata <= (r_op == OP_RD) ? bus.mem_rdata : '0;
        r_err   <= bus.mem_err | (w_tc_hit & ~bus.mem_done);
      end
    end
  end

  assign w_resp_if = (r_state == RESP) && (r_owner == OWN_IF);
  assign w_resp_dm = (r_state == RESP) && (r_owner == OWN_DM);

  assign bus.mem_rd    = (r_state == ISSUE) && (r_op == OP_RD);
  assign bus.mem_wr    = (r_state == ISSUE) && (r_op == OP_WR);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  assign bus.if_done   = w_resp_if;
  assign bus.if_err    = w_resp_if & r_err;
  assign bus.if_rdata  = w_resp_if ? r_rdata : '0;
  assign bus.dm_done   = w_resp_dm;
  assign bus.dm_err    = w_resp_dm & r_err;
  assign bus.dm_rdata  = w_resp_dm ? r_rdata : '0;

  assign bus.busy      = (r_state != IDLE);

endmodule
